// File: rtl/nf_strobe_gen_if.sv
// nf_strobe_gen_if: control/status bundle for nf_strobe_gen.
// master drives run, clr, mode and div and reads en, tgl, busy and done; slave is the generator side.
interface nf_strobe_gen_if #(
  parameter int CH = 2,
  parameter int DW = 26
);
  logic [CH-1:0]    run;
  logic [CH-1:0]    clr;
  logic [2*CH-1:0]  mode;
  logic [DW*CH-1:0] div;
  logic [CH-1:0]    en;
  logic [CH-1:0]    tgl;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    done;
  modport master (output run, clr, mode, div, input en, tgl, busy, done);
  modport slave (input run, clr, mode, div, output en, tgl, busy, done);
endinterface

// File: rtl/nf_strobe_gen.sv
// nf_strobe_gen: multi-channel clock-enable generator with periodic, toggle and one-shot modes.
// Ports: clk; resetn (async, active-low); bus (slave): run/clr/mode/div in, en/tgl/busy/done out, one bit or field per channel.
module nf_strobe_gen #(
  parameter int CH = 2,
  parameter int DW = 26
) (
  input logic            clk,
  input logic            resetn,
  nf_strobe_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  logic [CH-1:0] en_w, tgl_w, busy_w, done_w;
  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d, cmp_q, cmp_d, div_c;
    logic [1:0]    mode_q, mode_d, mode_c;
    logic          en_q, en_d, tgl_q, tgl_d, done_q, done_d, run_c, clr_c, hit;
    assign run_c  = bus.run[c];
    assign clr_c  = bus.clr[c];
    assign mode_c = bus.mode[2*c +: 2];
    assign div_c  = bus.div[DW*c +: DW];
    assign hit    = cnt_q == cmp_q;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        cmp_q   <= '0;
        mode_q  <= 2'b00;
        en_q    <= 1'b0;
        tgl_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cmp_q   <= cmp_d;
        mode_q  <= mode_d;
        en_q    <= en_d;
        tgl_q   <= tgl_d;
        done_q  <= done_d;
      end
    end
    // Priority inside RUN: run drop, then clr, then match.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmp_d   = cmp_q;
      mode_d  = mode_q;
      en_d    = 1'b0;
      tgl_d   = tgl_q;
      done_d  = done_q;
      if (state_q == IDLE) begin
        if (run_c) begin
          state_d = RUN;
          cnt_d   = '0;
          cmp_d   = div_c;
          mode_d  = mode_c;
        end
      end else if (state_q == RUN) begin
        if (!run_c) begin
          state_d = IDLE;
          cnt_d   = '0;
          tgl_d   = 1'b0;
        end else if (clr_c) begin
          cnt_d = '0;
          cmp_d = div_c;
          tgl_d = 1'b0;
        end else if (hit) begin
          en_d  = 1'b1;
          cnt_d = '0;
          cmp_d = div_c;
          tgl_d = (mode_q == 2'b01) ? ~tgl_q : tgl_q;
          if (mode_q == 2'b10) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end else if (!run_c) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    end
    assign en_w[c]   = en_q;
    assign tgl_w[c]  = tgl_q;
    assign busy_w[c] = state_q == RUN;
    assign done_w[c] = done_q;
  end
  assign bus.en   = en_w;
  assign bus.tgl  = tgl_w;
  assign bus.busy = busy_w;
  assign bus.done = done_w;
endmodule

// File: tb/tb_nf_strobe_gen.sv
// tb_nf_strobe_gen: table-driven bench with an expected-result queue for nf_strobe_gen (CH=2, DW=4).
module tb_nf_strobe_gen;
  localparam int CH = 2;
  localparam int DW = 4;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;
  nf_strobe_gen_if #(.CH(CH), .DW(DW)) bus ();
  nf_strobe_gen #(.CH(CH), .DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  typedef struct {
    logic [1:0] run;
    logic [1:0] clr;
    logic [3:0] mode;
    logic [7:0] div;
    logic [7:0] exp;
    string      name;
  } vec_t;
  typedef struct {
    logic [7:0] exp;
    string      name;
    int         idx;
  } sb_t;
  vec_t vecs[$];
  sb_t  sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [7:0] outs;
  assign outs = {bus.en, bus.tgl, bus.busy, bus.done};
  function automatic void add(input logic [1:0] run, input logic [1:0] clr, input logic [3:0] mode,
                              input logic [7:0] div, input logic [1:0] en, input logic [1:0] tgl,
                              input logic [1:0] busy, input logic [1:0] done, input string name);
    vec_t v;
    v.run  = run;
    v.clr  = clr;
    v.mode = mode;
    v.div  = div;
    v.exp  = {en, tgl, busy, done};
    v.name = name;
    vecs.push_back(v);
  endfunction
  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: en/tgl/busy/done got %b_%b_%b_%b, want %b_%b_%b_%b", name, idx,
               act[7:6], act[5:4], act[3:2], act[1:0], exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask
  task automatic tick_check(input string name, input int idx, input logic [7:0] exp);
    @(posedge clk);
    #1;
    check(name, idx, outs, exp);
  endtask
  initial begin
    sb_t e;
    bus.run  = '0;
    bus.clr  = '0;
    bus.mode = '0;
    bus.div  = '0;
    #1 resetn = 1'b0;
    #2 check("reset_state", 0, outs, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    // periodic, div0=3, channel 1 idle
    for (int k = 0; k < 9; k++)
      add(2'b01, 2'b00, 4'h0, 8'h03, (k == 4 || k == 8) ? 2'b01 : 2'b00, 2'b00, 2'b01, 2'b00, "per_div3");
    add(2'b00, 2'b00, 4'h0, 8'h03, 2'b00, 2'b00, 2'b00, 2'b00, "per_div3_stop");
    add(2'b00, 2'b01, 4'h0, 8'h03, 2'b00, 2'b00, 2'b00, 2'b00, "clr_idle");
    // div0=0 holds en continuously
    add(2'b01, 2'b00, 4'h0, 8'h00, 2'b00, 2'b00, 2'b01, 2'b00, "div0_start");
    for (int k = 1; k < 4; k++)
      add(2'b01, 2'b00, 4'h0, 8'h00, 2'b01, 2'b00, 2'b01, 2'b00, "div0_cont");
    add(2'b00, 2'b00, 4'h0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, "div0_stop");
    // both channels div=2 started together: ch0 periodic, ch1 toggle
    for (int k = 0; k < 10; k++)
      add(2'b11, 2'b00, 4'b0100, 8'h22, (k == 3 || k == 6 || k == 9) ? 2'b11 : 2'b00,
          ((k >= 3 && k < 6) || k >= 9) ? 2'b10 : 2'b00, 2'b11, 2'b00, "tgl_aligned");
    add(2'b00, 2'b00, 4'b0100, 8'h22, 2'b00, 2'b00, 2'b00, 2'b00, "tgl_stop");
    // one-shot div0=4, clr ignored in DONE, then re-armed
    for (int k = 0; k < 5; k++)
      add(2'b01, 2'b00, 4'b0010, 8'h04, 2'b00, 2'b00, 2'b01, 2'b00, "os_wait");
    add(2'b01, 2'b00, 4'b0010, 8'h04, 2'b01, 2'b00, 2'b00, 2'b01, "os_fire");
    add(2'b01, 2'b01, 4'b0010, 8'h04, 2'b00, 2'b00, 2'b00, 2'b01, "os_clr_done");
    add(2'b01, 2'b00, 4'b0010, 8'h04, 2'b00, 2'b00, 2'b00, 2'b01, "os_hold");
    add(2'b00, 2'b00, 4'b0010, 8'h04, 2'b00, 2'b00, 2'b00, 2'b00, "os_release");
    for (int k = 0; k < 5; k++)
      add(2'b01, 2'b00, 4'b0010, 8'h04, 2'b00, 2'b00, 2'b01, 2'b00, "os2_wait");
    add(2'b01, 2'b00, 4'b0010, 8'h04, 2'b01, 2'b00, 2'b00, 2'b01, "os2_fire");
    add(2'b01, 2'b00, 4'b0010, 8'h04, 2'b00, 2'b00, 2'b00, 2'b01, "os2_hold");
    add(2'b00, 2'b00, 4'b0010, 8'h04, 2'b00, 2'b00, 2'b00, 2'b00, "os2_release");
    // div 5 -> 1 changed mid-run, mode change ignored, clr restart
    add(2'b01, 2'b00, 4'h0, 8'h05, 2'b00, 2'b00, 2'b01, 2'b00, "chg_e0");
    add(2'b01, 2'b00, 4'h0, 8'h05, 2'b00, 2'b00, 2'b01, 2'b00, "chg_e1");
    add(2'b01, 2'b00, 4'h0, 8'h01, 2'b00, 2'b00, 2'b01, 2'b00, "chg_e2");
    add(2'b01, 2'b00, 4'h1, 8'h01, 2'b00, 2'b00, 2'b01, 2'b00, "chg_e3");
    add(2'b01, 2'b00, 4'h1, 8'h01, 2'b00, 2'b00, 2'b01, 2'b00, "chg_e4");
    add(2'b01, 2'b00, 4'h1, 8'h01, 2'b00, 2'b00, 2'b01, 2'b00, "chg_e5");
    add(2'b01, 2'b00, 4'h1, 8'h01, 2'b01, 2'b00, 2'b01, 2'b00, "chg_e6");
    add(2'b01, 2'b00, 4'h1, 8'h01, 2'b00, 2'b00, 2'b01, 2'b00, "chg_e7");
    add(2'b01, 2'b00, 4'h1, 8'h01, 2'b01, 2'b00, 2'b01, 2'b00, "chg_e8");
    add(2'b01, 2'b01, 4'h1, 8'h01, 2'b00, 2'b00, 2'b01, 2'b00, "chg_clr_e9");
    add(2'b01, 2'b00, 4'h1, 8'h01, 2'b00, 2'b00, 2'b01, 2'b00, "chg_e10");
    add(2'b01, 2'b00, 4'h1, 8'h01, 2'b01, 2'b00, 2'b01, 2'b00, "chg_e11");
    add(2'b00, 2'b00, 4'h1, 8'h01, 2'b00, 2'b00, 2'b00, 2'b00, "chg_stop");
    // mode 11 on channel 1 behaves as periodic
    for (int k = 0; k < 5; k++)
      add(2'b10, 2'b00, 4'b1100, 8'h10, (k == 2 || k == 4) ? 2'b10 : 2'b00, 2'b00, 2'b10, 2'b00, "mode11");
    add(2'b00, 2'b00, 4'b1100, 8'h10, 2'b00, 2'b00, 2'b00, 2'b00, "mode11_stop");
    // div all-ones: period 2^DW, no overflow
    for (int k = 0; k < 17; k++)
      add(2'b01, 2'b00, 4'h0, 8'h0F, (k == 16) ? 2'b01 : 2'b00, 2'b00, 2'b01, 2'b00, "div_max");
    add(2'b00, 2'b00, 4'h0, 8'h0F, 2'b00, 2'b00, 2'b00, 2'b00, "div_max_stop");
    foreach (vecs[i]) begin
      bus.run  = vecs[i].run;
      bus.clr  = vecs[i].clr;
      bus.mode = vecs[i].mode;
      bus.div  = vecs[i].div;
      sb.push_back('{vecs[i].exp, vecs[i].name, i});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(e.name, e.idx, outs, e.exp);
    end
    // asynchronous reset while en is high, then idle until run is sampled again
    bus.run = 2'b01;
    bus.clr = 2'b00;
    bus.mode = 4'h0;
    bus.div = 8'h02;
    for (int k = 0; k < 3; k++) tick_check("rst_pre", k, 8'b00_00_01_00);
    tick_check("rst_pre_en", 3, 8'b01_00_01_00);
    #2 resetn = 1'b0;
    #1 check("rst_async", 0, outs, 8'h00);
    bus.run = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) tick_check("rst_idle", k, 8'h00);
    bus.run = 2'b01;
    tick_check("rst_restart", 0, 8'b00_00_01_00);
    tick_check("rst_restart", 1, 8'b00_00_01_00);
    tick_check("rst_restart", 2, 8'b00_00_01_00);
    tick_check("rst_restart_en", 3, 8'b01_00_01_00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nf_strobe_gen.md
Name: nf_strobe_gen

Overview:
Multi-channel, parametrised clock-enable generator and the successor to the single-channel enable-strobe divider.
Each channel has its own divider value, run control, synchronous restart and mode select:
- periodic strobe,
- toggle (square wave),
- one-shot.

Outputs are registered, so they can drive peripheral timing (UART baud, PWM, GPIO debounce sampling) directly.

Parameters:
CH, 2, number of independent channels (>=1)
DW, 26, divider/counter width in bits (>=1)

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
run  input  CH  per-channel run request (level)
clr  input  CH  per-channel synchronous restart (single-cycle pulse or level)
mode  input  2*CH  per-channel mode, channel i at [2i+1:2i]: 00 periodic, 01 toggle, 10 one-shot, 11 treated as periodic
div  input  DW*CH  per-channel divider, channel i at [DW*i+DW-1:DW*i]; period = div+1 clk cycles
en  output  CH  per-channel enable strobe, registered
tgl  output  CH  per-channel square-wave output, registered
busy  output  CH  high while channel is in RUN
done  output  CH  one-shot complete flag, registered, level

Behaviour:
- Channels are fully independent. Per channel there is a DW-bit counter cnt, a DW-bit compare register cmp, a latched 2-bit mode_q, and a state of IDLE, RUN or DONE.
- Reset (async, resetn=0) forces state=IDLE, cnt=0, cmp=0, mode_q=00, en=0, tgl=0, done=0 on all channels. busy=0.
- Reset mid-operation aborts immediately with no pending strobe.
- busy = (state==RUN), combinational from state.

State transitions:
- IDLE, run=1 at edge E: state RUN, cnt=0, cmp=div, mode_q=mode.
- RUN, run=0: state IDLE, cnt=0, en=0, tgl=0. This has priority over match.
- RUN, clr=1 (run=1): cnt=0, cmp=div, tgl=0, en=0, stay RUN. clr has priority over match.
  - clr in IDLE or DONE has no effect.
  - mode_q is NOT reloaded on clr.
- RUN, cnt==cmp: match. At that edge:
  - en<=1, cnt<=0, cmp<=div (new div takes effect here).
  - mode_q=01: tgl<=~tgl.
  - mode_q=10: state<=DONE, done<=1.
- RUN, no match: cnt<=cnt+1, en<=0.
- DONE: en=0, done=1, tgl holds; run=0 moves to IDLE and clears done.

Timing and arithmetic:
- en is high for exactly one cycle per match. Periodic timing:
  - First en rises at edge E+div+1.
  - Subsequent en pulses rise every div+1 edges.
  - div=0 gives en held continuously high in periodic/toggle mode.
- In toggle mode tgl has period 2*(div+1) cycles and changes on the same edges where en rises.
- div changes while in RUN are ignored until the next match or clr.
- mode changes while in RUN/DONE are ignored until the next IDLE->RUN.
- cnt never exceeds cmp. With div=all-ones the period is 2^DW cycles and no overflow occurs.
- Simultaneous run rise on several channels yields aligned strobes for equal div values.

Test Plan:
- CH=2, div0=3, mode0=00, run0 at edge 0 -> en0 high in cycles after edges 4,8,12,...; busy0=1; channel 1 stays idle with en1=tgl1=busy1=0.
- div0=0, mode0=00, run0=1 -> en0 continuously 1 from edge 1; drop run0 -> en0=0 and busy0=0 after the next edge.
- div1=2, mode1=01 -> tgl1 rises at edge 3, falls at edge 6, rises at edge 9 (period 6); en1 pulses at 3,6,9.
- div0=4, mode0=10 -> single en0 pulse after edge 5; done0=1, busy0=0 thereafter; run0 low -> done0=0; run0 high again -> new pulse 5 edges later.
- Periodic div0=5, change div0 to 1 at edge 2 -> next en at edge 6, then edges 8,10,...; clr0 at edge 9 with run0=1 -> no en at edge 10, next en at edge 11.
- resetn low mid-run at arbitrary cycle -> all outputs 0 asynchronously; after release, channels remain IDLE until run is sampled.
